// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg: shared state, field encodings and BCD limits for the RTC set path.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EDIT_HOUR = 3'd1,
    EDIT_MIN  = 3'd2,
    EDIT_SEC  = 3'd3,
    COMMIT    = 3'd4,
    HOST_CHK  = 3'd5
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // True when both nibbles are decimal digits and the value does not exceed lim.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_field_inc.sv
// ---------------------------------------------------------------------------
// bcd_field_inc: combinational two-digit BCD +1, wrapping to 00 past max_i.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_field_inc (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  output logic [7:0] nxt_o
);

  always_comb begin
    nxt_o = 8'h00;
    if (val_i >= max_i) begin
      nxt_o = 8'h00;
    end else if (val_i[3:0] >= 4'd9) begin
      nxt_o = {val_i[7:4] + 4'd1, 4'd0};
    end else begin
      nxt_o = {val_i[7:4], val_i[3:0] + 4'd1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/rtc_set_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_set_ctrl: arbitrates button editing and host sync onto the RTC load port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 30,
  parameter int HOST_PRIORITY  = 1
) (
  input  logic        d_clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] cur_time,
  input  logic        host_req,
  input  logic [23:0] host_time,
  output logic        set,
  output logic [7:0]  set_hour,
  output logic [7:0]  set_min,
  output logic [7:0]  set_sec,
  output logic        host_ack,
  output logic        host_err,
  output logic        editing,
  output logic [1:0]  edit_field
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       edit_hour_q, edit_hour_d;
  logic [7:0]       edit_min_q, edit_min_d;
  logic [7:0]       edit_sec_q, edit_sec_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             armed_q, armed_d;
  logic             set_q, set_d;
  logic [7:0]       set_hour_q, set_hour_d;
  logic [7:0]       set_min_q, set_min_d;
  logic [7:0]       set_sec_q, set_sec_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             editing_q, editing_d;
  logic [1:0]       field_q, field_d;

  logic [7:0]       inc_val;
  logic [7:0]       inc_max;
  logic [7:0]       inc_nxt;
  logic             host_go;
  logic             host_valid;

  bcd_field_inc u_inc (
    .val_i (inc_val),
    .max_i (inc_max),
    .nxt_o (inc_nxt)
  );

  // armed_q blocks a request that is still high after its own ack.
  assign host_go    = host_req && armed_q;
  assign host_valid = bcd_in_range(host_time[23:16], HOUR_MAX)
                   && bcd_in_range(host_time[15:8], MINSEC_MAX)
                   && bcd_in_range(host_time[7:0], MINSEC_MAX);

  always_comb begin
    inc_val = edit_hour_q;
    inc_max = HOUR_MAX;
    case (state_q)
      EDIT_MIN: begin
        inc_val = edit_min_q;
        inc_max = MINSEC_MAX;
      end
      EDIT_SEC: begin
        inc_val = edit_sec_q;
        inc_max = MINSEC_MAX;
      end
      default: ;
    endcase
  end

  // Outputs are computed for the state being entered, so a strobe appears
  // in the cycle right after the deciding edge.
  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    edit_sec_d  = edit_sec_q;
    tmo_d       = tmo_q;
    armed_d     = armed_q;
    set_d       = 1'b0;
    set_hour_d  = set_hour_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;

    if (!host_req) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (host_go && ((HOST_PRIORITY != 0) || !btn_mode)) begin
          state_d = HOST_CHK;
          armed_d = 1'b0;
          ack_d   = 1'b1;
          if (host_valid) begin
            set_d      = 1'b1;
            set_hour_d = host_time[23:16];
            set_min_d  = host_time[15:8];
            set_sec_d  = host_time[7:0];
          end else begin
            err_d = 1'b1;
          end
        end else if (btn_mode) begin
          state_d     = EDIT_HOUR;
          edit_hour_d = cur_time[23:16];
          edit_min_d  = cur_time[15:8];
          edit_sec_d  = cur_time[7:0];
        end
      end

      EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
        if (btn_inc) begin
          case (state_q)
            EDIT_HOUR: edit_hour_d = inc_nxt;
            EDIT_MIN:  edit_min_d  = inc_nxt;
            default:   edit_sec_d  = inc_nxt;
          endcase
        end

        if (btn_mode || btn_inc) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end

        if (btn_mode) begin
          case (state_q)
            EDIT_HOUR: state_d = EDIT_MIN;
            EDIT_MIN:  state_d = EDIT_SEC;
            default: begin
              state_d    = COMMIT;
              set_d      = 1'b1;
              set_hour_d = edit_hour_d;
              set_min_d  = edit_min_d;
              set_sec_d  = edit_sec_d;
            end
          endcase
        end
      end

      COMMIT:   state_d = IDLE;
      HOST_CHK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    editing_d = 1'b0;
    field_d   = FIELD_NONE;
    case (state_d)
      EDIT_HOUR: begin editing_d = 1'b1; field_d = FIELD_HOUR; end
      EDIT_MIN:  begin editing_d = 1'b1; field_d = FIELD_MIN;  end
      EDIT_SEC:  begin editing_d = 1'b1; field_d = FIELD_SEC;  end
      default: ;
    endcase
  end

  always_ff @(posedge d_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      edit_hour_q <= 8'h00;
      edit_min_q  <= 8'h00;
      edit_sec_q  <= 8'h00;
      tmo_q       <= '0;
      armed_q     <= 1'b1;
      set_q       <= 1'b0;
      set_hour_q  <= 8'h00;
      set_min_q   <= 8'h00;
      set_sec_q   <= 8'h00;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      editing_q   <= 1'b0;
      field_q     <= FIELD_NONE;
    end else begin
      state_q     <= state_d;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      tmo_q       <= tmo_d;
      armed_q     <= armed_d;
      set_q       <= set_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      editing_q   <= editing_d;
      field_q     <= field_d;
    end
  end

  assign set        = set_q;
  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign set_sec    = set_sec_q;
  assign host_ack   = ack_q;
  assign host_err   = err_q;
  assign editing    = editing_q;
  assign edit_field = field_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rtc_set_ctrl: directed vectors with hand-computed results for rtc_set_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rtc_set_ctrl;

  logic        d_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [23:0] cur_time = 24'h0;
  logic        host_req = 1'b0;
  logic [23:0] host_time = 24'h0;
  logic        set;
  logic [7:0]  set_hour;
  logic [7:0]  set_min;
  logic [7:0]  set_sec;
  logic        host_ack;
  logic        host_err;
  logic        editing;
  logic [1:0]  edit_field;

  int n_tot = 0;
  int n_bad = 0;
  int set_seen;

  rtc_set_ctrl #(
    .TIMEOUT_CYCLES (30),
    .HOST_PRIORITY  (1)
  ) dut (
    .d_clk      (d_clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_time   (cur_time),
    .host_req   (host_req),
    .host_time  (host_time),
    .set        (set),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .host_ack   (host_ack),
    .host_err   (host_err),
    .editing    (editing),
    .edit_field (edit_field)
  );

  always #5 d_clk = ~d_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock with the given button pulses; returns at the following negedge.
  task automatic cyc(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge d_clk);
    @(negedge d_clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic chk_load(input string tag, input logic [23:0] t);
    chk({tag, "_set"}, {31'd0, set}, 32'd1);
    chk({tag, "_time"}, {8'd0, set_hour, set_min, set_sec}, {8'd0, t});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge d_clk);
    @(negedge d_clk);
    chk("rst_set", {31'd0, set}, 32'd0);
    chk("rst_time", {8'd0, set_hour, set_min, set_sec}, 32'd0);
    chk("rst_ack", {30'd0, host_ack, host_err}, 32'd0);
    chk("rst_edit", {29'd0, editing, edit_field}, 32'd0);
    rst_n = 1'b1;
    cyc(0, 0);

    // btn_inc in IDLE does nothing
    cyc(0, 1);
    chk("idle_inc", {29'd0, editing, edit_field}, 32'd0);

    // edit 23:59:58 -> 00:01:58
    cur_time = 24'h235958;
    cyc(1, 0);
    chk("e1_field", {29'd0, editing, edit_field}, {29'd0, 1'b1, 2'd1});
    cyc(0, 1);
    cyc(1, 0);
    chk("e1_field2", {30'd0, edit_field}, 32'd2);
    cyc(0, 1);
    cyc(0, 1);
    cyc(1, 0);
    chk("e1_field3", {30'd0, edit_field}, 32'd3);
    chk("e1_noset", {31'd0, set}, 32'd0);
    cyc(1, 0);
    chk_load("e1_commit", 24'h000158);
    chk("e1_field0", {29'd0, editing, edit_field}, 32'd0);
    cyc(0, 0);
    chk("e1_setlow", {31'd0, set}, 32'd0);
    chk("e1_hold", {8'd0, set_hour, set_min, set_sec}, 32'h000158);

    // unit carry and simultaneous mode+inc: 09:49:59 -> 10:50:00
    cur_time = 24'h094959;
    cyc(1, 0);
    cyc(0, 1);
    cyc(1, 0);
    cyc(0, 1);
    cyc(1, 0);
    cyc(1, 1);
    chk_load("e2_commit", 24'h105000);

    // timeout after 30 idle cycles in edit
    cur_time = 24'h101010;
    cyc(0, 0);
    cyc(1, 0);
    set_seen = 0;
    for (int k = 0; k < 29; k++) begin
      cyc(0, 0);
      if (set) set_seen++;
    end
    chk("tmo_still", {31'd0, editing}, 32'd1);
    cyc(0, 0);
    if (set) set_seen++;
    chk("tmo_exit", {29'd0, editing, edit_field}, 32'd0);
    chk("tmo_noset", set_seen, 32'd0);
    chk("tmo_hold", {8'd0, set_hour, set_min, set_sec}, 32'h105000);

    // host valid load, request held past the ack
    host_time = 24'h124530;
    host_req  = 1'b1;
    cyc(0, 0);
    chk_load("hv", 24'h124530);
    chk("hv_ack", {30'd0, host_ack, host_err}, 32'b10);
    cyc(0, 0);
    chk("hv_ack_lo", {30'd0, host_ack, set}, 32'd0);
    cyc(0, 0);
    chk("hv_held", {30'd0, host_ack, set}, 32'd0);
    host_req = 1'b0;
    cyc(0, 0);

    // host invalid load
    host_time = 24'h246000;
    host_req  = 1'b1;
    cyc(0, 0);
    chk("hi_ack", {29'd0, host_ack, host_err, set}, 32'b110);
    chk("hi_hold", {8'd0, set_hour, set_min, set_sec}, 32'h124530);
    host_req = 1'b0;
    cyc(0, 0);

    // contention in IDLE: host wins, mode dropped
    host_time = 24'h010203;
    host_req  = 1'b1;
    cyc(1, 0);
    chk("ct_ack", {29'd0, host_ack, host_err, editing}, 32'b100);
    chk_load("ct", 24'h010203);
    host_req = 1'b0;
    cyc(0, 0);
    chk("ct_noedit", {31'd0, editing}, 32'd0);

    // host request during EDIT_MIN waits for commit
    cur_time = 24'h000000;
    cyc(1, 0);
    cyc(1, 0);
    host_time = 24'h222222;
    host_req  = 1'b1;
    cyc(0, 0);
    chk("hw_noack1", {31'd0, host_ack}, 32'd0);
    cyc(1, 0);
    chk("hw_noack2", {31'd0, host_ack}, 32'd0);
    cyc(1, 0);
    chk_load("hw_commit", 24'h000000);
    chk("hw_noack3", {31'd0, host_ack}, 32'd0);
    cyc(0, 0);
    chk("hw_gap", {30'd0, host_ack, set}, 32'd0);
    cyc(0, 0);
    chk("hw_ack", {30'd0, host_ack, host_err}, 32'b10);
    chk_load("hw", 24'h222222);
    host_req = 1'b0;
    cyc(0, 0);

    // asynchronous reset mid-edit
    cyc(1, 0);
    chk("ar_pre", {31'd0, editing}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_edit", {29'd0, editing, edit_field}, 32'd0);
    chk("ar_time", {8'd0, set_hour, set_min, set_sec}, 32'd0);
    @(negedge d_clk);
    rst_n = 1'b1;
    cyc(0, 0);
    chk("ar_after", {30'd0, set, editing}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
